// File: rtl/uart_frame_serializer.sv
// Frame-to-character sender for UART_TX: emits a FRAME_WIDTH word MSB byte first as start/ready handshakes.
// Define UART_FRAME_CHECKSUM_EN to append one XOR checksum character after the frame bytes.
module uart_frame_serializer #(
    parameter int DATA_SIZE   = 8,
    parameter int FRAME_WIDTH = 72
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_valid,
    input  logic [FRAME_WIDTH-1:0] frame_data,
    output logic                   frame_ready,
    output logic                   byte_start,
    output logic [DATA_SIZE-1:0]   byte_data,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int BYTE_COUNT = FRAME_WIDTH / DATA_SIZE;
    localparam int CW         = $clog2(BYTE_COUNT + 1);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int LAST_CHAR  = BYTE_COUNT;
`else
    localparam int LAST_CHAR  = BYTE_COUNT - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LAST_CHAR);

    typedef enum logic [2:0] {IDLE, SEND, WBUSY, WIDLE, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [FRAME_WIDTH-1:0] shreg_reg;
    logic [CW-1:0]          count_reg;
    logic [DATA_SIZE-1:0]   byte_data_reg;
    logic                   byte_start_reg, frame_ready_reg, busy_reg, frame_done_reg;
    logic                   load, fire, advance;
    logic [DATA_SIZE-1:0]   next_byte;

`ifdef UART_FRAME_CHECKSUM_EN
    logic [DATA_SIZE-1:0]   csum_reg;

    // The character after the last frame byte is the running XOR instead of shifted data.
    assign next_byte = (count_reg == CW'(BYTE_COUNT - 1)) ? csum_reg
                                                           : shreg_reg[FRAME_WIDTH-DATA_SIZE-1 -: DATA_SIZE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_reg <= '0;
        end else if (load) begin
            csum_reg <= '0;
        end else if (fire) begin
            csum_reg <= csum_reg ^ byte_data_reg;
        end
    end
`else
    assign next_byte = shreg_reg[FRAME_WIDTH-DATA_SIZE-1 -: DATA_SIZE];
`endif

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        fire       = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_valid) begin
                    load       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    fire       = 1'b1;
                    state_next = WBUSY;
                end
            end
            WBUSY: begin
                if (!byte_ready) state_next = WIDLE;
            end
            WIDLE: begin
                if (byte_ready) begin
                    if (count_reg == LAST_CNT) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = SEND;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            shreg_reg       <= '0;
            count_reg       <= '0;
            byte_data_reg   <= '0;
            byte_start_reg  <= 1'b0;
            frame_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            byte_start_reg  <= fire;
            frame_ready_reg <= (state_next == IDLE);
            busy_reg        <= (state_next != IDLE);
            frame_done_reg  <= (state_next == DONE);
            if (load) begin
                shreg_reg     <= frame_data;
                count_reg     <= '0;
                byte_data_reg <= frame_data[FRAME_WIDTH-1 -: DATA_SIZE];
            end else if (advance) begin
                shreg_reg     <= shreg_reg << DATA_SIZE;
                count_reg     <= count_reg + 1'b1;
                byte_data_reg <= next_byte;
            end
        end
    end

    assign frame_ready = frame_ready_reg;
    assign byte_start  = byte_start_reg;
    assign byte_data   = byte_data_reg;
    assign busy        = busy_reg;
    assign frame_done  = frame_done_reg;
endmodule
